// File: rtl/lbist_pkg.sv
// Shared definitions for the LBIST response compactor: FSM encoding, MISR geometry
// and the default seed.
package lbist_pkg;

    localparam int MISR_W = 8;
    localparam int CNT_W  = 9;

    // Taps for x^8+x^6+x^5+x^4+1 on a left-shifting register: bits 7,5,4,3.
    localparam logic [MISR_W-1:0] TAP_MASK     = 8'hB8;
    localparam logic [MISR_W-1:0] DEFAULT_SEED = 8'h00;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_COMPACT = 2'd1,
        ST_WRITE   = 2'd2,
        ST_DONE    = 2'd3
    } lbist_state_t;

endpackage

// File: rtl/lbist_misr8.sv
// 8-bit multiple-input signature register with seed load and update enable.
// The next value is exported so the controller can capture the closing signature.
module lbist_misr8
    import lbist_pkg::*;
#(
    parameter logic [MISR_W-1:0] SEED = DEFAULT_SEED
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              load,
    input  logic              enable,
    input  logic [MISR_W-1:0] data_in,
    output logic [MISR_W-1:0] misr_next
);

    logic [MISR_W-1:0] misr;
    logic              feedback;

    assign feedback  = ^(misr & TAP_MASK);
    assign misr_next = {misr[MISR_W-2:0], feedback} ^ data_in;

    // Load wins over enable so a window boundary always restarts from the seed.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            misr <= SEED;
        end else if (load) begin
            misr <= SEED;
        end else if (enable) begin
            misr <= misr_next;
        end
    end

endmodule

// File: rtl/lbist_misr_ctrl.sv
// LBIST response compactor: folds PATTERNS_PER_SIG accepted responses into a MISR,
// strobes each signature to the signature RAM, and repeats for NUM_SIGS windows.
module lbist_misr_ctrl
    import lbist_pkg::*;
#(
    parameter int                PATTERNS_PER_SIG = 16,
    parameter int                NUM_SIGS         = 8,
    parameter logic [MISR_W-1:0] SEED             = DEFAULT_SEED
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [MISR_W-1:0] resp_in,
    input  logic              resp_valid,
    output logic              resp_ready,
    output logic [MISR_W-1:0] data_out,
    output logic              wr,
    output logic              sig_zero,
    output logic [7:0]        sig_cnt,
    output logic              busy,
    output logic              done
);

    localparam logic [CNT_W-1:0] PAT_LAST  = CNT_W'(PATTERNS_PER_SIG - 1);
    localparam logic [CNT_W-1:0] SIG_TOTAL = CNT_W'(NUM_SIGS);

    lbist_state_t      state;
    lbist_state_t      state_next;
    logic [CNT_W-1:0]  pat_cnt;
    logic [CNT_W-1:0]  sig_count;
    logic [CNT_W-1:0]  sig_count_inc;
    logic [MISR_W-1:0] misr_next;
    logic              accept;
    logic              window_end;
    logic              run_init;
    logic              misr_load;

    assign accept        = (state == ST_COMPACT) && resp_valid;
    assign window_end    = accept && (pat_cnt == PAT_LAST);
    assign sig_count_inc = sig_count + CNT_W'(1);
    assign sig_cnt       = sig_count[7:0];

    lbist_misr8 #(
        .SEED (SEED)
    ) u_misr (
        .clk       (clk),
        .rst_n     (rst_n),
        .load      (misr_load),
        .enable    (accept),
        .data_in   (resp_in),
        .misr_next (misr_next)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        run_init   = 1'b0;
        misr_load  = 1'b0;
        case (state)
            ST_IDLE, ST_DONE: begin
                if (start) begin
                    state_next = ST_COMPACT;
                    run_init   = 1'b1;
                    misr_load  = 1'b1;
                end
            end
            ST_COMPACT: begin
                if (window_end) begin
                    state_next = ST_WRITE;
                end
            end
            ST_WRITE: begin
                misr_load  = 1'b1;
                state_next = (sig_count_inc == SIG_TOTAL) ? ST_DONE : ST_COMPACT;
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pat_cnt   <= '0;
            sig_count <= '0;
        end else if (run_init) begin
            pat_cnt   <= '0;
            sig_count <= '0;
        end else begin
            if (accept) begin
                pat_cnt <= window_end ? '0 : pat_cnt + CNT_W'(1);
            end
            if (state == ST_WRITE) begin
                sig_count <= sig_count_inc;
            end
        end
    end

    // Signature is captured on the closing accept so data_out lines up with wr.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            data_out <= '0;
            sig_zero <= 1'b0;
        end else if (window_end) begin
            data_out <= misr_next;
            sig_zero <= (misr_next == '0);
        end
    end

    // Status outputs are registered from the next state to stay glitch-free.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr         <= 1'b0;
            resp_ready <= 1'b0;
            busy       <= 1'b0;
            done       <= 1'b0;
        end else begin
            wr         <= (state_next == ST_WRITE);
            resp_ready <= (state_next == ST_COMPACT);
            busy       <= (state_next == ST_COMPACT) || (state_next == ST_WRITE);
            done       <= (state_next == ST_DONE);
        end
    end

endmodule

// File: tb/tb_lbist_misr_ctrl.sv
// Bench for lbist_misr_ctrl: vector table, hand sequences for tap/zero cases, and a
// randomized run against a window-level signature model.
module tb_lbist_misr_ctrl;

    localparam int          P_A    = 4;
    localparam int          N_A    = 3;
    localparam logic [7:0]  SEED_A = 8'h5A;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    // DUT A: random/model run, mid-run reset, restart from DONE
    logic       s_a = 0, v_a = 0, rdy_a, wr_a, sz_a, busy_a, done_a;
    logic [7:0] d_a = 0, data_a, cnt_a;
    // DUT B: single-bit propagation table
    logic       s_b = 0, v_b = 0, rdy_b, wr_b, sz_b, busy_b, done_b;
    logic [7:0] d_b = 0, data_b, cnt_b;
    // DUT C: feedback tap
    logic       s_c = 0, v_c = 0, rdy_c, wr_c, sz_c, busy_c, done_c;
    logic [7:0] d_c = 0, data_c, cnt_c;
    // DUT D: zero signature
    logic       s_d = 0, v_d = 0, rdy_d, wr_d, sz_d, busy_d, done_d;
    logic [7:0] d_d = 0, data_d, cnt_d;

    lbist_misr_ctrl #(.PATTERNS_PER_SIG(P_A), .NUM_SIGS(N_A), .SEED(SEED_A)) dut_a (
        .clk(clk), .rst_n(rst_n), .start(s_a), .resp_in(d_a), .resp_valid(v_a),
        .resp_ready(rdy_a), .data_out(data_a), .wr(wr_a), .sig_zero(sz_a),
        .sig_cnt(cnt_a), .busy(busy_a), .done(done_a));

    lbist_misr_ctrl #(.PATTERNS_PER_SIG(2), .NUM_SIGS(1), .SEED(8'h00)) dut_b (
        .clk(clk), .rst_n(rst_n), .start(s_b), .resp_in(d_b), .resp_valid(v_b),
        .resp_ready(rdy_b), .data_out(data_b), .wr(wr_b), .sig_zero(sz_b),
        .sig_cnt(cnt_b), .busy(busy_b), .done(done_b));

    lbist_misr_ctrl #(.PATTERNS_PER_SIG(1), .NUM_SIGS(2), .SEED(8'h80)) dut_c (
        .clk(clk), .rst_n(rst_n), .start(s_c), .resp_in(d_c), .resp_valid(v_c),
        .resp_ready(rdy_c), .data_out(data_c), .wr(wr_c), .sig_zero(sz_c),
        .sig_cnt(cnt_c), .busy(busy_c), .done(done_c));

    lbist_misr_ctrl #(.PATTERNS_PER_SIG(4), .NUM_SIGS(1), .SEED(8'h00)) dut_d (
        .clk(clk), .rst_n(rst_n), .start(s_d), .resp_in(d_d), .resp_valid(v_d),
        .resp_ready(rdy_d), .data_out(data_d), .wr(wr_d), .sig_zero(sz_d),
        .sig_cnt(cnt_d), .busy(busy_d), .done(done_d));

    // {resp_ready, busy, done, wr, sig_zero, sig_cnt, data_out}
    function automatic logic [20:0] pk(input logic rdy, input logic bsy, input logic dn,
                                       input logic w, input logic sz,
                                       input logic [7:0] cnt, input logic [7:0] dat);
        return {rdy, bsy, dn, w, sz, cnt, dat};
    endfunction

    task automatic check(input string name, input logic [20:0] act, input logic [20:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got rdy,busy,done,wr,zero=%b cnt=%h data=%h, want %b cnt=%h data=%h",
                     name, act[20:16], act[15:8], act[7:0], exp[20:16], exp[15:8], exp[7:0]);
        end
    endtask

    task automatic check_int(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, want %0d", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Reference signature: seed folded over one window of responses.
    function automatic logic [7:0] fold(input logic [7:0] q[$]);
        int s;
        int fb;
        s = int'(SEED_A);
        foreach (q[i]) begin
            fb = ((s >> 7) ^ (s >> 5) ^ (s >> 4) ^ (s >> 3)) & 1;
            s  = (((s * 2) & 255) | fb) ^ int'(q[i]);
        end
        return 8'(s);
    endfunction

    // Window-level model of DUT A: 0 idle, 1 collecting, 2 strobe cycle, 3 finished
    int         m_mode = 0;
    int         m_nsig = 0;
    int         m_wrs  = 0;
    logic [7:0] m_last = 8'h00;
    logic       m_sz   = 1'b0;
    logic       m_took = 1'b0;
    logic [7:0] m_acc[$];
    logic [7:0] stream[P_A*N_A];

    task automatic model_reset();
        m_mode = 0; m_nsig = 0; m_last = 8'h00; m_sz = 1'b0; m_acc.delete();
    endtask

    task automatic a_cycle(input logic st, input logic v, input logic [7:0] d, input string tag);
        s_a = st; v_a = v; d_a = d;
        m_took = 1'b0;
        case (m_mode)
            0, 3: if (st) begin m_mode = 1; m_nsig = 0; m_acc.delete(); end
            1: if (v) begin
                m_took = 1'b1;
                m_acc.push_back(d);
                if (m_acc.size() == P_A) begin
                    m_last = fold(m_acc);
                    m_sz   = (m_last == 8'h00);
                    m_acc.delete();
                    m_mode = 2;
                end
            end
            2: begin
                m_nsig++;
                m_mode = (m_nsig == N_A) ? 3 : 1;
            end
            default: m_mode = 0;
        endcase
        tick();
        if (wr_a) m_wrs++;
        check(tag, pk(rdy_a, busy_a, done_a, wr_a, sz_a, cnt_a, data_a),
              pk(m_mode == 1, m_mode == 1 || m_mode == 2, m_mode == 3, m_mode == 2,
                 m_sz, 8'(m_nsig), m_last));
    endtask

    // Full run on DUT A with random stalls; valid forced high during the strobe cycle.
    task automatic run_a(input string tag);
        int idx;
        int cyc;
        logic v;
        logic [7:0] d;
        idx = 0;
        m_wrs = 0;
        a_cycle(1'b1, 1'b0, 8'h00, {tag, "_start"});
        cyc = 0;
        while (m_mode != 3 && cyc < 200) begin
            v = (m_mode == 2) ? 1'b1 : 1'($urandom_range(0, 1));
            d = (m_mode == 1 && idx < P_A*N_A) ? stream[idx] : 8'($urandom);
            a_cycle(1'b0, v, d, $sformatf("%s_cyc%0d", tag, cyc));
            if (m_took) idx++;
            cyc++;
        end
        check_int({tag, "_finished"}, int'(m_mode == 3), 1);
        check_int({tag, "_wr_pulses"}, m_wrs, N_A);
        check_int({tag, "_consumed"}, idx, P_A*N_A);
        a_cycle(1'b0, 1'b1, 8'hC3, {tag, "_done_hold"});
    endtask

    typedef struct {
        logic        start;
        logic        v;
        logic [7:0]  d;
        logic [20:0] exp;
    } vec_t;

    vec_t tbl[9];

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        // DUT B vectors: resp 01 then 00 from seed 00 gives signature 02
        tbl[0] = '{1'b1, 1'b0, 8'h00, pk(1, 1, 0, 0, 0, 8'd0, 8'h00)};
        tbl[1] = '{1'b0, 1'b1, 8'h01, pk(1, 1, 0, 0, 0, 8'd0, 8'h00)};
        tbl[2] = '{1'b0, 1'b1, 8'h00, pk(0, 1, 0, 1, 0, 8'd0, 8'h02)};
        tbl[3] = '{1'b0, 1'b1, 8'hFF, pk(0, 0, 1, 0, 0, 8'd1, 8'h02)};
        tbl[4] = '{1'b0, 1'b0, 8'h00, pk(0, 0, 1, 0, 0, 8'd1, 8'h02)};
        tbl[5] = '{1'b1, 1'b0, 8'h00, pk(1, 1, 0, 0, 0, 8'd0, 8'h02)};
        tbl[6] = '{1'b0, 1'b1, 8'h01, pk(1, 1, 0, 0, 0, 8'd0, 8'h02)};
        tbl[7] = '{1'b0, 1'b1, 8'h00, pk(0, 1, 0, 1, 0, 8'd0, 8'h02)};
        tbl[8] = '{1'b0, 1'b0, 8'h00, pk(0, 0, 1, 0, 0, 8'd1, 8'h02)};
        for (int i = 0; i < P_A*N_A; i++) stream[i] = 8'($urandom);

        // Reset state
        tick(); tick();
        check("reset_a", pk(rdy_a, busy_a, done_a, wr_a, sz_a, cnt_a, data_a), '0);
        check("reset_b", pk(rdy_b, busy_b, done_b, wr_b, sz_b, cnt_b, data_b), '0);
        check("reset_c", pk(rdy_c, busy_c, done_c, wr_c, sz_c, cnt_c, data_c), '0);
        check("reset_d", pk(rdy_d, busy_d, done_d, wr_d, sz_d, cnt_d, data_d), '0);
        rst_n = 1'b1;
        tick();

        // Single-bit propagation and restart, table-driven
        for (int i = 0; i < 9; i++) begin
            s_b = tbl[i].start; v_b = tbl[i].v; d_b = tbl[i].d;
            tick();
            check($sformatf("tbl_b[%0d]", i),
                  pk(rdy_b, busy_b, done_b, wr_b, sz_b, cnt_b, data_b), tbl[i].exp);
        end
        s_b = 0; v_b = 0;

        // Feedback tap: seed 80 with zero response gives 01; strobe-cycle response ignored
        s_c = 1; tick(); s_c = 0;
        check("tap_start", pk(rdy_c, busy_c, done_c, wr_c, sz_c, cnt_c, data_c), pk(1, 1, 0, 0, 0, 8'd0, 8'h00));
        v_c = 1; d_c = 8'h00; tick();
        check("tap_wr1", pk(rdy_c, busy_c, done_c, wr_c, sz_c, cnt_c, data_c), pk(0, 1, 0, 1, 0, 8'd0, 8'h01));
        tick();
        check("tap_gap", pk(rdy_c, busy_c, done_c, wr_c, sz_c, cnt_c, data_c), pk(1, 1, 0, 0, 0, 8'd1, 8'h01));
        tick();
        check("tap_wr2", pk(rdy_c, busy_c, done_c, wr_c, sz_c, cnt_c, data_c), pk(0, 1, 0, 1, 0, 8'd1, 8'h01));
        v_c = 0; tick();
        check("tap_done", pk(rdy_c, busy_c, done_c, wr_c, sz_c, cnt_c, data_c), pk(0, 0, 1, 0, 0, 8'd2, 8'h01));

        // Zero signature is still strobed, flagged by sig_zero
        s_d = 1; tick(); s_d = 0;
        v_d = 1; d_d = 8'h00;
        tick(); tick(); tick();
        check("zero_collect", pk(rdy_d, busy_d, done_d, wr_d, sz_d, cnt_d, data_d), pk(1, 1, 0, 0, 0, 8'd0, 8'h00));
        tick();
        check("zero_wr", pk(rdy_d, busy_d, done_d, wr_d, sz_d, cnt_d, data_d), pk(0, 1, 0, 1, 1, 8'd0, 8'h00));
        v_d = 0; tick();
        check("zero_done", pk(rdy_d, busy_d, done_d, wr_d, sz_d, cnt_d, data_d), pk(0, 0, 1, 0, 1, 8'd1, 8'h00));

        // Asynchronous reset in the middle of a window
        model_reset();
        a_cycle(1'b1, 1'b0, 8'h00, "mid_start");
        a_cycle(1'b0, 1'b1, stream[0], "mid_acc0");
        a_cycle(1'b0, 1'b1, stream[1], "mid_acc1");
        #2 rst_n = 1'b0;
        #1;
        check("mid_reset_async", pk(rdy_a, busy_a, done_a, wr_a, sz_a, cnt_a, data_a), '0);
        model_reset();
        tick();
        rst_n = 1'b1;
        a_cycle(1'b0, 1'b1, 8'h11, "post_reset_idle0");
        a_cycle(1'b0, 1'b1, 8'h22, "post_reset_idle1");

        // Clean run with stalls, then restart from DONE with the same responses
        run_a("run1");
        run_a("run2");

        s_a = 0; v_a = 0;
        tick();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
